// File: rtl/mux_pkg.sv
// +----------------------------------------------------------------------------+
// | mux_pkg : shared defaults and width helper for the round-robin stream mux  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mux_pkg;

  localparam int c_n_default = 8;
  localparam int c_m_default = 8;

  // A single channel still needs a 1-bit select/pointer.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin grant, searching req upward from ptr|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int M  = c_m_default,
  localparam int SW = clog2_min1(M)
) (
  input  logic [M-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [2*M-1:0] w_dbl;
  logic [M-1:0]   w_rot;
  logic [SW-1:0]  w_off;
  logic [SW:0]    w_sum;

  always_comb begin
    // Rotating a doubled copy puts req[ptr] at bit 0 with wrap-around handled.
    w_dbl = {req, req} >> ptr;
    w_rot = w_dbl[M-1:0];
    w_off = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SW'(i);
    end
    w_sum = {1'b0, ptr} + {1'b0, w_off};
    if (w_sum >= (SW+1)'(M)) w_sum = w_sum - (SW+1)'(M);
    gnt_idx = w_sum[SW-1:0];
  end

  assign gnt_any = |req;

endmodule

`default_nettype wire

// File: rtl/rr_stream_mux.sv
// +----------------------------------------------------------------------------+
// | rr_stream_mux : M-input round-robin valid/ready mux with registered output |
// | Option: RR_STREAM_MUX_PKT_LOCK_EN holds the grant until in_last.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_stream_mux
  import mux_pkg::*;
#(
  parameter  int N  = c_n_default,
  parameter  int M  = c_m_default,
  localparam int SW = clog2_min1(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [M*N-1:0] in_data,
  input  logic [M-1:0]  in_valid,
  output logic [M-1:0]  in_ready,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_sel
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  ,
  input  logic [M-1:0]  in_last,
  output logic          out_last
`endif
);

  localparam logic [SW-1:0] c_last_idx = SW'(M - 1);

  logic [SW-1:0] r_ptr;
  logic [N-1:0]  r_out_data;
  logic          r_out_valid;
  logic [SW-1:0] r_out_sel;

  logic [SW-1:0] w_arb_idx;
  logic          w_arb_any;
  logic [SW-1:0] w_gnt;
  logic          w_any;
  logic          w_load_ok;
  logic          w_xfer;
  logic          w_adv;

  rr_arbiter #(.M(M)) u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .gnt_idx (w_arb_idx),
    .gnt_any (w_arb_any)
  );

  assign w_load_ok = !r_out_valid || out_ready;

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  logic          r_lock;
  logic [SW-1:0] r_lk;
  logic          r_out_last;

  // While a packet is open only the owning channel can be granted.
  assign w_gnt    = r_lock ? r_lk : w_arb_idx;
  assign w_any    = r_lock ? in_valid[r_lk] : w_arb_any;
  assign w_adv    = w_xfer && in_last[w_gnt];
  assign out_last = r_out_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock     <= 1'b0;
      r_lk       <= '0;
      r_out_last <= 1'b0;
    end else if (w_xfer) begin
      r_lock     <= !in_last[w_gnt];
      r_lk       <= w_gnt;
      r_out_last <= in_last[w_gnt];
    end
  end
`else
  assign w_gnt = w_arb_idx;
  assign w_any = w_arb_any;
  assign w_adv = w_xfer;
`endif

  assign w_xfer = w_any && w_load_ok && !rst;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < M; i++) begin
      in_ready[i] = w_xfer && (w_gnt == SW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_xfer) begin
        r_out_data  <= in_data[w_gnt*N +: N];
        r_out_sel   <= w_gnt;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_adv) begin
        r_ptr <= (w_gnt == c_last_idx) ? '0 : w_gnt + SW'(1);
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sel   = r_out_sel;

endmodule

`default_nettype wire

// File: tb/tb_rr_stream_mux.sv
// +----------------------------------------------------------------------------+
// | tb_rr_stream_mux : random stimulus + scoreboard for M=8 and M=5 instances  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rr_stream_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] bv  [2];
  logic [7:0] bd  [2][8];
  logic       bor [2];

  logic [63:0] d8;
  logic [39:0] d5;
  always_comb begin
    d8 = '0;
    d5 = '0;
    for (int i = 0; i < 8; i++) d8[i*8 +: 8] = bd[0][i];
    for (int i = 0; i < 5; i++) d5[i*8 +: 8] = bd[1][i];
  end

  logic [7:0] r8;
  logic [4:0] r5;
  logic [7:0] od8, od5;
  logic       ov8, ov5;
  logic [2:0] os8, os5;

  rr_stream_mux #(.N(8), .M(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (d8),
    .in_valid  (bv[0]),
    .in_ready  (r8),
    .out_data  (od8),
    .out_valid (ov8),
    .out_ready (bor[0]),
    .out_sel   (os8)
  );

  rr_stream_mux #(.N(8), .M(5)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (d5),
    .in_valid  (bv[1][4:0]),
    .in_ready  (r5),
    .out_data  (od5),
    .out_valid (ov5),
    .out_ready (bor[1]),
    .out_sel   (os5)
  );

  logic [7:0] ordy [2];
  logic [7:0] odat [2];
  logic       oval [2];
  logic [2:0] osel [2];
  assign ordy[0] = r8;
  assign ordy[1] = {3'b000, r5};
  assign odat[0] = od8;
  assign odat[1] = od5;
  assign oval[0] = ov8;
  assign oval[1] = ov5;
  assign osel[0] = os8;
  assign osel[1] = os5;

  typedef struct {
    logic [7:0] d;
    int         s;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int mptr      [2];
  bit mov       [2];
  int acc       [2];
  bit after_rst [2];
  int ncmp  = 0;
  int nfail = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d @%0t: got %0h, want %0h", nm, d, $time, act, exp);
    end
  endtask

  // mode 1: every channel continuously valid with data 0x10+i, consumer always ready
  task automatic step(input int mode, input int pv, input int pr, input bit r);
    int         m, g, c;
    logic [7:0] er;
    bit         lo;
    exp_t       e;
    @(negedge clk);
    rst = r;
    for (int d = 0; d < 2; d++) begin
      m = (d == 0) ? 8 : 5;
      if (acc[d] >= 0) bv[d][acc[d]] = 1'b0;
      for (int i = 0; i < m; i++) begin
        if (!bv[d][i]) begin
          if (mode == 1) begin
            bv[d][i] = 1'b1;
            bd[d][i] = 8'h10 + 8'(i);
          end else if ($urandom_range(99) < pv) begin
            bv[d][i] = 1'b1;
            bd[d][i] = 8'($urandom);
          end
        end
      end
      bor[d] = (mode == 1) ? 1'b1 : ($urandom_range(99) < pr);
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      m = (d == 0) ? 8 : 5;
      chk("out_valid", d, 32'(oval[d]), 32'(mov[d]));
      if (after_rst[d]) begin
        chk("rst_out_data", d, 32'(odat[d]), 32'h0);
        chk("rst_out_sel", d, 32'(osel[d]), 32'h0);
        after_rst[d] = 1'b0;
      end
      g = -1;
      if (!r) begin
        for (int k = 0; k < m; k++) begin
          c = (mptr[d] + k) % m;
          if (g < 0 && bv[d][c]) g = c;
        end
      end
      lo = !mov[d] || bor[d];
      er = '0;
      if (g >= 0 && lo) er[g] = 1'b1;
      chk("in_ready", d, 32'(ordy[d]), 32'(er));
      if (r) begin
        mov[d] = 1'b0;
        mptr[d] = 0;
        acc[d] = -1;
        after_rst[d] = 1'b1;
        if (d == 0) q0.delete(); else q1.delete();
      end else if (g >= 0 && lo) begin
        e.d = bd[d][g];
        e.s = g;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        mptr[d] = (g + 1) % m;
        mov[d] = 1'b1;
        acc[d] = g;
      end else begin
        acc[d] = -1;
        if (bor[d]) mov[d] = 1'b0;
      end
    end
  endtask

  // Monitor: every consumed output beat must match the oldest predicted beat.
  initial begin
    exp_t e;
    bit   empty;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          if (oval[d] && bor[d]) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
              ncmp++;
              nfail++;
              $display("FAIL sb_underflow dut%0d @%0t: got beat %0h, want none", d, $time, odat[d]);
            end else begin
              e = (d == 0) ? q0.pop_front() : q1.pop_front();
              chk("out_data", d, 32'(odat[d]), 32'(e.d));
              chk("out_sel", d, 32'(osel[d]), 32'(e.s));
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      bv[d] = '0;
      bor[d] = 1'b0;
      mptr[d] = 0;
      mov[d] = 1'b0;
      acc[d] = -1;
      after_rst[d] = 1'b1;
      for (int i = 0; i < 8; i++) bd[d][i] = '0;
    end
    step(0, 0, 0, 1'b1);
    step(0, 0, 0, 1'b1);
    repeat (24)  step(1, 0, 100, 1'b0);
    repeat (300) step(0, 60, 50, 1'b0);
    repeat (5)   step(0, 60, 100, 1'b0);
    step(0, 60, 100, 1'b1);
    repeat (300) step(0, 20, 70, 1'b0);
    repeat (200) step(0, 90, 30, 1'b0);
    repeat (30)  step(0, 0, 100, 1'b0);
    @(negedge clk);
    #3;
    chk("sb_leftover", 0, 32'(q0.size()), 32'h0);
    chk("sb_leftover", 1, 32'(q1.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised M-input, N-bit streaming multiplexer.
- Successor to the fixed 8:1 combinational mux: the channel count is generic, and the select is generated internally by a round-robin arbiter instead of an external switch.
- Each input and the output use a valid/ready handshake. The output is registered.
- Sits between multiple producers (e.g. per-unit result streams) and one shared consumer (bus or FIFO).

Parameters:
- N, 8, data width in bits per channel (>=1)
- M, 8, number of input channels (>=1; non-power-of-2 legal)
- SW, $clog2(M) (min 1), select/pointer width; derived localparam, not overridable

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- in_data  input  M*N  flattened channel data; channel i occupies [i*N +: N]
- in_valid  input  M  per-channel valid
- in_ready  output  M  per-channel ready; at most one bit high per cycle
- out_data  output  N  registered selected data
- out_valid  output  1  out_data holds a beat not yet consumed
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready
- out_sel  output  SW  channel index that produced the current out_data

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
  - in_ready is 0 while rst is high.
  - A beat held in the output register is discarded when reset is asserted mid-operation.
- Output stage may load: load_ok = !out_valid || out_ready. This is a combinational pass-through of ready, with no skid buffer.
- Grant (combinational):
  - Search in_valid starting at index ptr, ascending, wrapping from M-1 to 0.
  - The first set bit is the grant g; has_grant = |in_valid.
- in_ready[i] = has_grant && load_ok && (i==g) && !rst.
- Transfer on channel g when in_valid[g] && in_ready[g]. At that posedge:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - ptr <= (g==M-1) ? 0 : g+1.
- No transfer and out_ready && out_valid: out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one and out_valid stays 1. Full throughput is one beat per cycle.
- Latency: one cycle from input transfer to out_valid.
- Output stall (out_valid=1, out_ready=0): all in_ready=0 and ptr holds. Inputs must hold valid and data (AXI-style; the block does not check this).
- Fairness: with all M channels continuously valid and out_ready=1, grants cycle 0,1,…,M-1,0,… One channel gets no more than one beat per M transfers while the others are requesting.
- M=1: ptr is constant 0 and the block degenerates to a one-stage pipeline register.
- Idle (in_valid=0): ptr holds.

Optional Feature:
- Macro: RR_STREAM_MUX_PKT_LOCK_EN
- Defined:
  - Adds ports in_last [M] (input) and out_last [1] (output, registered with out_data, reset 0).
  - A lock flag (reset 0) is set when a transfer happens with in_last[g]=0, and is cleared on a transfer with in_last[g]=1.
  - While locked, the grant is forced to the locked channel lk (stored at lock time). Other channels see in_ready=0 even if the locked channel's valid is low.
  - ptr advances only on the transfer that carries last=1.
  - Reset clears the lock.
- Undefined: no last ports; every beat re-arbitrates as described in Behaviour.

Decomposition:
- Shared package mux_pkg:
  - function clog2_min1(int) for SW;
  - localparam defaults for N and M.
- One natural sub-module, rr_arbiter:
  - purely combinational, parameter M;
  - inputs req[M], ptr[SW]; outputs gnt_idx[SW], gnt_any.
  - Implementation: double-width rotate-and-priority-encode.
- The lock flag, ptr, and output register live in rr_stream_mux.

Test Plan:
- Reset mid-stream: out_valid=1 with out_data=0x5A, assert rst one cycle → out_valid=0, out_data=0, out_sel=0; next arbitration starts at channel 0.
- M=8, all in_valid=1, out_ready=1, in_data[i]=0x10+i → out_data sequence 0x10,0x11…0x17,0x10, one per cycle after a 1-cycle latency; out_sel matches.
- Backpressure: out_ready=0 for 3 cycles with channel 2 valid → out_valid stays 1, out_data holds, in_ready=0, ptr unchanged; after out_ready=1, channel 3 is served next if valid.
- Sparse/wrap with M=5: only channels 4 and 1 valid, ptr=2 → grant 4, then 1, then 4 (wrap from 4 to 0 checked); non-power-of-2 select never exceeds 4.
- Drain-and-load: out_valid=1, out_ready=1, channel 0 valid with 0xAB → same cycle in_ready[0]=1, next cycle out_data=0xAB with out_valid continuously 1.
- With RR_STREAM_MUX_PKT_LOCK_EN: channel 1 sends a 3-beat packet (last on beat 3) while channels 0 and 2 are valid → beats 1,1,1 emitted consecutively, then channel 2. A channel-1 valid gap mid-packet gives no grant to the others.
